matrix_row_seq: RTL and testbench

MATRIX_ROW_SEQ -- requirements
Module: matrix_row_seq

---
 rtl/matrix_row_seq.sv | 174 +++++++++++++++++
 tb/tb_matrix_row_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_seq.sv
// Row sequencer for matrix_ops: latches an A row, streams B rows 0..7 and accumulates mm_co.
// Build option: define MM_ACC_INIT_EN to add c_init, which seeds the accumulator on start.
module matrix_row_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] a_row,
`ifdef MM_ACC_INIT_EN
  input  logic [255:0] c_init,
`endif
  output logic         b_rd_en,
  output logic [2:0]   b_rd_addr,
  input  logic [255:0] b_rd_data,
  output logic         mm_en,
  output logic [5:0]   mm_op,
  output logic [255:0] mm_a,
  output logic [255:0] mm_b,
  output logic [255:0] mm_cin,
  input  logic [255:0] mm_co,
  output logic         busy,
  output logic         done,
  output logic [255:0] result
);

  localparam int unsigned ROW_W  = 256;
  localparam int unsigned K_W    = 3;
  localparam int unsigned OP_W   = 6;
  localparam logic [K_W-1:0] K_LAST = K_W'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_MAC   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [ROW_W-1:0] acc_q, acc_d;
  logic [ROW_W-1:0] a_q, a_d;
  logic [ROW_W-1:0] result_q, result_d;
  logic             b_rd_en_q, b_rd_en_d;
  logic [K_W-1:0]   b_rd_addr_q, b_rd_addr_d;
  logic             mm_en_q, mm_en_d;
  logic [OP_W-1:0]  mm_op_q, mm_op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;
  logic [ROW_W-1:0] acc_init_c;

  assign accept_c = (state_q == S_IDLE) && start;

`ifdef MM_ACC_INIT_EN
  assign acc_init_c = c_init;
`else
  assign acc_init_c = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = '0;
        end
      end
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Output and datapath next values; outputs are registered from the upcoming state
  always_comb begin
    acc_d       = acc_q;
    a_d         = a_q;
    result_d    = result_q;
    b_rd_en_d   = 1'b0;
    b_rd_addr_d = '0;
    mm_en_d     = 1'b0;
    mm_op_d     = '0;
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);

    if (accept_c) begin
      a_d   = a_row;
      acc_d = acc_init_c;
    end else if (state_q == S_MAC) begin
      acc_d = mm_co;
    end

    // Last MAC result goes straight to result so it is valid alongside done
    if ((state_q == S_MAC) && (k_q == K_LAST)) begin
      result_d = mm_co;
    end

    if (state_d == S_FETCH) begin
      b_rd_en_d   = 1'b1;
      b_rd_addr_d = '0;
    end else if (state_d == S_MAC) begin
      mm_en_d = 1'b1;
      mm_op_d = OP_W'(k_d) + OP_W'(1);
      if (k_d != K_LAST) begin
        b_rd_en_d   = 1'b1;
        b_rd_addr_d = k_d + K_W'(1);
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      a_q         <= '0;
      result_q    <= '0;
      b_rd_en_q   <= 1'b0;
      b_rd_addr_q <= '0;
      mm_en_q     <= 1'b0;
      mm_op_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      a_q         <= a_d;
      result_q    <= result_d;
      b_rd_en_q   <= b_rd_en_d;
      b_rd_addr_q <= b_rd_addr_d;
      mm_en_q     <= mm_en_d;
      mm_op_q     <= mm_op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign b_rd_en   = b_rd_en_q;
  assign b_rd_addr = b_rd_addr_q;
  assign mm_en     = mm_en_q;
  assign mm_op     = mm_op_q;
  assign mm_a      = a_q;
  // B data only forwarded while a MAC is active, so it reads 0 in reset and idle
  assign mm_b      = mm_en_q ? b_rd_data : '0;
  assign mm_cin    = acc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_matrix_row_seq.sv
// Scoreboard bench for matrix_row_seq with a B-row memory model and a scalar matrix_ops model.
module tb_matrix_row_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] a_row;
  logic         b_rd_en;
  logic [2:0]   b_rd_addr;
  logic [255:0] b_rd_data = '0;
  logic         mm_en;
  logic [5:0]   mm_op;
  logic [255:0] mm_a, mm_b, mm_cin, mm_co;
  logic         busy, done;
  logic [255:0] result;
`ifdef MM_ACC_INIT_EN
  logic [255:0] c_init = 256'd100;
  localparam logic [255:0] CI = 256'd100;
`else
  localparam logic [255:0] CI = 256'd0;
`endif

  logic [255:0] bmem [8];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  typedef struct {
    logic [255:0] res;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];

  matrix_row_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_row     (a_row),
`ifdef MM_ACC_INIT_EN
    .c_init    (c_init),
`endif
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr),
    .b_rd_data (b_rd_data),
    .mm_en     (mm_en),
    .mm_op     (mm_op),
    .mm_a      (mm_a),
    .mm_b      (mm_b),
    .mm_cin    (mm_cin),
    .mm_co     (mm_co),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // B-row memory: data appears the cycle after the read strobe
  always @(posedge clk) if (b_rd_en) b_rd_data <= bmem[b_rd_addr];

  // matrix_ops stand-in: cin + A[op-1] * B (scalar, mod 2^256)
  function automatic logic [255:0] mops(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] cin, input logic [5:0] op);
    logic [31:0] e;
    e = '0;
    if (op >= 6'd1 && op <= 6'd8) e = a[32*(int'(op)-1) +: 32];
    return cin + 256'(e) * b;
  endfunction

  assign mm_co = mops(mm_a, mm_b, mm_cin, mm_op);

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected row, in value and cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 256'(1), 256'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 256'(sb_q.size()), 256'(0));
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // One row with cycle-accurate checks of the B-read and MAC sequencing
  task automatic do_row(input logic [255:0] a, input logic [255:0] exp_res);
    int e;
    @(negedge clk);
    start = 1'b1;
    a_row = a;
    @(negedge clk);
    start = 1'b0;
    a_row = ~a;
    e = cyc;
    sb_q.push_back('{res: exp_res, cyc: e + 9});
    chk("fetch_busy", 256'(busy), 256'(1));
    chk("fetch_rd_en", 256'(b_rd_en), 256'(1));
    chk("fetch_rd_addr", 256'(b_rd_addr), 256'(0));
    chk("fetch_mm_op", 256'(mm_op), 256'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mac_mm_en", 256'(mm_en), 256'(1));
      chk("mac_mm_op", 256'(mm_op), 256'(i + 1));
      chk("mac_rd_en", 256'(b_rd_en), (i < 7) ? 256'(1) : 256'(0));
      if (i < 7) chk("mac_rd_addr", 256'(b_rd_addr), 256'(i + 1));
      if (i == 0) chk("mac0_cin", mm_cin, CI);
    end
    @(negedge clk);
    chk("done_mm_op", 256'(mm_op), 256'(0));
    chk("done_mm_en", 256'(mm_en), 256'(0));
    drain();
  endtask

  logic [255:0] a_ones, a_e3, a_wrap, wrap_exp;
  int           e0, n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_row = '0;
    for (int k = 0; k < 8; k++) bmem[k] = '0;
    a_ones = {8{32'd1}};
    a_e3   = '0;
    a_e3[3*32 +: 32] = 32'd5;
    a_wrap = '0;
    a_wrap[31:0] = 32'hFFFF_FFFF;
    // (2^32-1)*(2^256-1) mod 2^256 = 2^256 - (2^32-1)
    wrap_exp = 256'd0 - 256'h0000_0000_FFFF_FFFF;

    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_rd_en", 256'(b_rd_en), 256'(0));
    chk("rst_mm_op", 256'(mm_op), 256'(0));
    chk("rst_result", result, 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) bmem[k] = 256'(k + 1);
    do_row(a_ones, 256'd36 + CI);
    chk("result_held", result, 256'd36 + CI);

    for (int k = 0; k < 8; k++) bmem[k] = 256'(k + 7);
    bmem[3] = 256'h10;
    do_row(a_e3, 256'h50 + CI);

    for (int k = 0; k < 8; k++) bmem[k] = 256'(k + 3);
    bmem[0] = '1;
    do_row(a_wrap, wrap_exp + CI);

    // start held high: second acceptance 11 edges after the first
    for (int k = 0; k < 8; k++) bmem[k] = 256'(k + 1);
    @(negedge clk);
    start = 1'b1;
    a_row = a_ones;
    @(negedge clk);
    e0 = cyc;
    sb_q.push_back('{res: 256'd36 + CI, cyc: e0 + 9});
    sb_q.push_back('{res: 256'd36 + CI, cyc: e0 + 20});
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      chk("b2b_busy", 256'(busy), (j == 10) ? 256'(0) : 256'(1));
    end
    start = 1'b0;
    drain();

    // Reset in MAC k=4 abandons the row
    @(negedge clk);
    start = 1'b1;
    a_row = a_ones;
    @(negedge clk);
    start = 1'b0;
    sb_q.push_back('{res: 256'd36 + CI, cyc: cyc + 9});
    n = 0;
    while (mm_op !== 6'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("reach_k4", 256'(mm_op), 256'(5));
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    chk("arst_busy", 256'(busy), 256'(0));
    chk("arst_done", 256'(done), 256'(0));
    chk("arst_rd_en", 256'(b_rd_en), 256'(0));
    chk("arst_rd_addr", 256'(b_rd_addr), 256'(0));
    chk("arst_mm_en", 256'(mm_en), 256'(0));
    chk("arst_mm_op", 256'(mm_op), 256'(0));
    chk("arst_mm_a", mm_a, 256'(0));
    chk("arst_mm_b", mm_b, 256'(0));
    chk("arst_mm_cin", mm_cin, 256'(0));
    chk("arst_result", result, 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_idle", 256'(busy), 256'(0));

    for (int k = 0; k < 8; k++) bmem[k] = 256'(k + 7);
    bmem[3] = 256'h10;
    do_row(a_e3, 256'h50 + CI);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
